// File: rtl/ear_pulsegen.sv
// ear_pulsegen: on each vs falling edge emits a burst of PULSES square-wave periods on mic.
// Optional macro EARPULSE_BURSTCNT_EN adds a wrapping 8-bit completed-burst counter output.
module ear_pulsegen #(
    parameter int HALF_PERIOD = 2168,
    parameter int PULSES      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vs,
    input  logic       enable,
    output logic       mic,
    output logic       busy,
    output logic       done
`ifdef EARPULSE_BURSTCNT_EN
    ,
    output logic [7:0] burst_cnt
`endif
);
    localparam logic [15:0] RELOAD = 16'(HALF_PERIOD - 1);
    localparam logic [7:0]  NPULSE = 8'(PULSES);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t      r_state;
    logic [1:0]  r_vs;
    logic [15:0] r_cnt;
    logic [7:0]  r_per;
    logic        r_mic;
    logic        r_busy;
    logic        r_done;
    logic        w_fall;
    logic        w_expire;
    logic        w_finish;

    assign w_fall   = r_vs == 2'b10;
    assign w_expire = r_cnt == 16'd0;
    assign w_finish = r_state == LOW && w_expire && !(r_per < NPULSE);

    // vs history {prev, cur}; reset to "high" so a low vs right after reset is not an edge by itself
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_vs <= 2'b11;
        else        r_vs <= {r_vs[0], vs};

    // burst sequencer: IDLE waits for an edge, HIGH/LOW time each half period, r_per counts periods started
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_per   <= '0;
            r_mic   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (!enable) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_per   <= '0;
            r_mic   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (w_fall && !r_done) begin
                    r_state <= HIGH;
                    r_cnt   <= RELOAD;
                    r_per   <= 8'd1;
                    r_mic   <= 1'b1;
                    r_busy  <= 1'b1;
                end
                HIGH: if (w_expire) begin
                    r_state <= LOW;
                    r_cnt   <= RELOAD;
                    r_mic   <= 1'b0;
                end else begin
                    r_cnt <= r_cnt - 16'd1;
                end
                LOW: if (w_finish) begin
                    r_state <= IDLE;
                    r_per   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end else if (w_expire) begin
                    r_state <= HIGH;
                    r_cnt   <= RELOAD;
                    r_per   <= r_per + 8'd1;
                    r_mic   <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - 16'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mic  = r_mic;
    assign busy = r_busy;
    assign done = r_done;

`ifdef EARPULSE_BURSTCNT_EN
    logic [7:0] r_burst_cnt;

    // counts normal completions only; steps on the same edge that raises done
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)                      r_burst_cnt <= '0;
        else if (enable && w_finish)     r_burst_cnt <= r_burst_cnt + 8'd1;

    assign burst_cnt = r_burst_cnt;
`endif
endmodule

// File: tb/tb_ear_pulsegen.sv
// tb_ear_pulsegen: directed checks of ear_pulsegen at HALF_PERIOD=4/PULSES=3 and HALF_PERIOD=2/PULSES=1.
module tb_ear_pulsegen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vs = 1'b1;
    logic vs1 = 1'b1;
    logic enable = 1'b0;
    logic mic, busy, done;
    logic mic1, busy1, done1;
`ifdef EARPULSE_BURSTCNT_EN
    logic [7:0] burst_cnt, burst_cnt1;
`endif
    int total = 0;
    int bad = 0;
    logic [7:0] exp_bc = 8'd0;

    always #5 clk = ~clk;

    ear_pulsegen #(.HALF_PERIOD(4), .PULSES(3)) dut (
        .clk(clk), .rst_n(rst_n), .vs(vs), .enable(enable),
        .mic(mic), .busy(busy), .done(done)
`ifdef EARPULSE_BURSTCNT_EN
        , .burst_cnt(burst_cnt)
`endif
    );

    ear_pulsegen #(.HALF_PERIOD(2), .PULSES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .vs(vs1), .enable(enable),
        .mic(mic1), .busy(busy1), .done(done1)
`ifdef EARPULSE_BURSTCNT_EN
        , .burst_cnt(burst_cnt1)
`endif
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fall();
        vs = 1'b1;
        tick();
        tick();
        vs = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({mic, busy, done} !== 3'b000) begin
            bad++;
            $display("FAIL reset_async: got %b want 000", {mic, busy, done});
        end
`ifdef EARPULSE_BURSTCNT_EN
        total++;
        if (burst_cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset_bc: got %0d want 0", burst_cnt);
        end
`endif
        tick();
        rst_n = 1'b1;
        enable = 1'b1;
        tick();
        tick();
        total++;
        if ({mic, busy, done, mic1, busy1, done1} !== 6'b0) begin
            bad++;
            $display("FAIL reset_idle: got %b want 000000", {mic, busy, done, mic1, busy1, done1});
        end
    endtask

    task automatic test_basic();
        logic e;
        fall();
        tick();
        total++;
        if ({mic, busy} !== 2'b00) begin
            bad++;
            $display("FAIL basic_latency: got %b want 00", {mic, busy});
        end
        for (int i = 0; i < 24; i++) begin
            tick();
            e = ((i / 4) % 2) == 0;
            total++;
            if ({mic, busy, done} !== {e, 2'b10}) begin
                bad++;
                $display("FAIL basic_burst[%0d]: got %b want %b", i, {mic, busy, done}, {e, 2'b10});
            end
        end
        tick();
        exp_bc++;
        total++;
        if ({mic, busy, done} !== 3'b001) begin
            bad++;
            $display("FAIL basic_done: got %b want 001", {mic, busy, done});
        end
`ifdef EARPULSE_BURSTCNT_EN
        total++;
        if (burst_cnt !== exp_bc) begin
            bad++;
            $display("FAIL basic_bc: got %0d want %0d", burst_cnt, exp_bc);
        end
`endif
        tick();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL basic_done_clear: got %b want 0", done);
        end
    endtask

    task automatic test_retrigger();
        int nbusy = 0;
        int ndone = 0;
        fall();
        tick();
        for (int i = 0; i < 40; i++) begin
            tick();
            nbusy += busy;
            ndone += done;
            if (i == 9) vs = 1'b1;
            if (i == 11) vs = 1'b0;
        end
        exp_bc++;
        total++;
        if (nbusy !== 24) begin
            bad++;
            $display("FAIL retrigger_len: got %0d want 24", nbusy);
        end
        total++;
        if (ndone !== 1) begin
            bad++;
            $display("FAIL retrigger_done: got %0d want 1", ndone);
        end
    endtask

    task automatic test_back_to_back();
        fall();
        tick();
        for (int i = 0; i < 24; i++) begin
            tick();
            if (i == 20) vs = 1'b1;
            if (i == 23) vs = 1'b0;
        end
        tick();
        exp_bc++;
        total++;
        if ({busy, done} !== 2'b01) begin
            bad++;
            $display("FAIL b2b_done: got %b want 01", {busy, done});
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if ({mic, busy} !== 2'b00) begin
                bad++;
                $display("FAIL b2b_ignored[%0d]: got %b want 00", i, {mic, busy});
            end
        end
        fall();
        tick();
        tick();
        total++;
        if ({mic, busy} !== 2'b11) begin
            bad++;
            $display("FAIL b2b_next: got %b want 11", {mic, busy});
        end
        repeat (24) tick();
        exp_bc++;
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_next_done: got %b want 1", done);
        end
    endtask

    task automatic test_abort();
        int ndone = 0;
        int nbusy = 0;
        fall();
        tick();
        for (int i = 0; i < 6; i++) tick();
        total++;
        if ({mic, busy} !== 2'b01) begin
            bad++;
            $display("FAIL abort_pre: got %b want 01", {mic, busy});
        end
        enable = 1'b0;
        tick();
        total++;
        if ({mic, busy, done} !== 3'b000) begin
            bad++;
            $display("FAIL abort_now: got %b want 000", {mic, busy, done});
        end
        for (int i = 0; i < 30; i++) begin
            tick();
            ndone += done;
            nbusy += busy;
        end
        total++;
        if (ndone + nbusy !== 0) begin
            bad++;
            $display("FAIL abort_quiet: got done=%0d busy=%0d want 0 0", ndone, nbusy);
        end
`ifdef EARPULSE_BURSTCNT_EN
        total++;
        if (burst_cnt !== exp_bc) begin
            bad++;
            $display("FAIL abort_bc: got %0d want %0d", burst_cnt, exp_bc);
        end
`endif
        enable = 1'b1;
        nbusy = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            nbusy += busy;
        end
        total++;
        if (nbusy !== 0) begin
            bad++;
            $display("FAIL enable_vs_low: got busy cycles %0d want 0", nbusy);
        end
    endtask

    task automatic test_reset_mid();
        int nbusy = 0;
        int ndone = 0;
        fall();
        tick();
        tick();
        tick();
        vs = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        exp_bc = 8'd0;
        total++;
        if ({mic, busy, done} !== 3'b000) begin
            bad++;
            $display("FAIL reset_mid: got %b want 000", {mic, busy, done});
        end
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            nbusy += busy;
        end
        total++;
        if (nbusy !== 0) begin
            bad++;
            $display("FAIL reset_mid_quiet: got busy cycles %0d want 0", nbusy);
        end
        fall();
        for (int i = 0; i < 30; i++) begin
            tick();
            nbusy += busy;
            ndone += done;
        end
        exp_bc++;
        total++;
        if ({nbusy, ndone} !== {32'd24, 32'd1}) begin
            bad++;
            $display("FAIL reset_mid_burst: got busy=%0d done=%0d want 24 1", nbusy, ndone);
        end
    endtask

    task automatic test_pulses1();
        logic [3:0] pat = 4'b1100;
        vs1 = 1'b0;
        tick();
        total++;
        if (mic1 !== 1'b0) begin
            bad++;
            $display("FAIL p1_latency: got %b want 0", mic1);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if ({mic1, busy1, done1} !== {pat[3 - i], 2'b10}) begin
                bad++;
                $display("FAIL p1_burst[%0d]: got %b want %b", i, {mic1, busy1, done1}, {pat[3 - i], 2'b10});
            end
        end
        tick();
        total++;
        if ({mic1, busy1, done1} !== 3'b001) begin
            bad++;
            $display("FAIL p1_done: got %b want 001", {mic1, busy1, done1});
        end
        vs1 = 1'b1;
    endtask

`ifdef EARPULSE_BURSTCNT_EN
    task automatic test_burstcnt();
        logic [7:0] start = exp_bc;
        for (int n = 0; n < 257; n++) begin
            fall();
            repeat (27) tick();
            exp_bc++;
        end
        total++;
        if (burst_cnt !== start + 8'd1) begin
            bad++;
            $display("FAIL burstcnt_wrap: got %0d want %0d", burst_cnt, start + 8'd1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_retrigger();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_pulses1();
`ifdef EARPULSE_BURSTCNT_EN
        test_burstcnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ear_pulsegen.md
EAR_PULSEGEN -- requirements
Module: ear_pulsegen

Interface
REQ-001 Parameter HALF_PERIOD, default 2168, clk cycles per half-period of the output square wave; legal range 2..65535.
REQ-002 Parameter PULSES, default 8, full periods per burst; legal range 1..255.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 vs  input  1  vertical sync, asynchronous to clk; each falling edge requests one burst.
REQ-006 enable  input  1  high permits bursts; low aborts and blocks them.
REQ-007 mic  output  1  registered square-wave test signal toward the tape/EAR path; idle level 0.
REQ-008 busy  output  1  registered; high while a burst is in progress.
REQ-009 done  output  1  registered; one-cycle strobe on normal burst completion.

Function
REQ-010 The block SHALL sample vs into a 2-bit shift register {prev, cur}; a falling edge is the register value 2'b10.
REQ-011 The FSM SHALL have states IDLE, HIGH, LOW; encoding is free.
REQ-012 IDLE -> HIGH when the falling edge is seen and enable=1; mic=1 and busy=1 on the next clock edge, i.e. the second rising edge at which vs is sampled low.
REQ-013 A 16-bit half-period counter SHALL reload on every state entry; mic stays high exactly HALF_PERIOD cycles in HIGH, low exactly HALF_PERIOD cycles in LOW.
REQ-014 HIGH -> LOW on counter expiry; LOW -> HIGH on expiry while the 8-bit period counter < PULSES; otherwise LOW -> IDLE.
REQ-015 Total busy time SHALL be exactly 2*HALF_PERIOD*PULSES cycles; mic SHALL show exactly PULSES rising and PULSES falling edges.
REQ-016 On LOW -> IDLE completion, done=1 for exactly one cycle, coincident with busy falling to 0.
REQ-017 vs falling edges while busy=1 SHALL be ignored, with no retrigger and no queuing.
REQ-018 A vs falling edge in the same cycle as done SHALL be ignored; the next edge starts a burst.
REQ-019 enable=0 in any state SHALL force IDLE on the next edge with mic=0, busy=0, done=0; no done strobe on abort.
REQ-020 enable rising while vs is already low SHALL NOT start a burst; only a new falling edge does.
REQ-021 At PULSES=1 the burst SHALL be a single HIGH/LOW pair.

Reset
REQ-022 rst_n=0 SHALL immediately force IDLE, mic=0, busy=0, done=0, both counters=0, and the vs shift register=2'b11, independent of clk.
REQ-023 Reset asserted mid-burst SHALL abandon the burst; after release the block waits for a fresh vs falling edge.

Configuration
REQ-024 Macro EARPULSE_BURSTCNT_EN SHALL add output burst_cnt [7:0]: reset 0, +1 in the cycle done is asserted, wraps 255 -> 0, unchanged by aborts.
REQ-025 Without EARPULSE_BURSTCNT_EN the port and counter SHALL be absent; all other behaviour is identical.

Verification (HALF_PERIOD=4, PULSES=3 unless noted)
REQ-026 enable=1, vs 1->0 -> mic high 2 edges after first low sample; pattern 1111 0000 x3; busy high 24 cycles; done one cycle at end.
REQ-027 Second vs fall 10 cycles into the burst -> burst length unchanged at 24 cycles; no second burst.
REQ-028 enable->0 at cycle 6 of the burst -> mic=0, busy=0 next edge; done never asserted; with macro, burst_cnt unchanged.
REQ-029 rst_n pulsed low mid-HIGH without a clk edge -> mic=0, busy=0 immediately; no activity until the next vs fall.
REQ-030 With EARPULSE_BURSTCNT_EN, 257 complete bursts -> burst_cnt=1; PULSES=1, HALF_PERIOD=2 -> mic 1100 and busy 4 cycles.
